// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequences clear/write/read/flush/output strobes and kernel address for the conv array
module conv_seq_ctrl #(
    parameter int R_F      = 3,
    parameter int C_F      = 3,
    parameter int In_Add_W = 4,
    parameter int MAC_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                hold,
    input  logic                abort,
    output logic                clk_en,
    output logic                clr,
    output logic                en_wr,
    output logic                en_rd,
    output logic                wr,
    output logic                en_MAC,
    output logic                en_MAC_out,
    output logic [In_Add_W-1:0] addr,
    output logic                busy,
    output logic                done,
    output logic                y_valid
);
    localparam int K  = R_F * C_F;
    localparam int CW = In_Add_W > 4 ? In_Add_W : 4;
    localparam logic [CW-1:0] K_LAST = CW'(K - 1);
    localparam logic [CW-1:0] F_LAST = CW'(MAC_LAT > 0 ? MAC_LAT - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_WRITE, S_READ, S_FLUSH, S_OUT, S_DONE} state_t;

    state_t st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic frz;
    logic clk_en_q, clr_q, en_wr_q, en_rd_q, wr_q, en_mac_q, en_mac_out_q, busy_q, done_q, y_valid_q;
    logic [In_Add_W-1:0] addr_q;

    // next step: start only from IDLE, then abort beats hold, hold freezes, otherwise advance the schedule
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        frz   = 1'b0;
        if (st_q == S_IDLE) begin
            if (start) begin
                st_d  = S_CLR;
                cnt_d = '0;
            end
        end else if (abort) begin
            st_d  = S_IDLE;
            cnt_d = '0;
        end else if (hold) begin
            frz = 1'b1;
        end else begin
            case (st_q)
                S_CLR: begin
                    st_d  = S_WRITE;
                    cnt_d = '0;
                end
                S_WRITE: begin
                    st_d  = cnt_q == K_LAST ? S_READ : S_WRITE;
                    cnt_d = cnt_q == K_LAST ? '0 : cnt_q + CW'(1);
                end
                S_READ: begin
                    st_d  = cnt_q != K_LAST ? S_READ : (MAC_LAT > 0 ? S_FLUSH : S_OUT);
                    cnt_d = cnt_q == K_LAST ? '0 : cnt_q + CW'(1);
                end
                S_FLUSH: begin
                    st_d  = cnt_q == F_LAST ? S_OUT : S_FLUSH;
                    cnt_d = cnt_q == F_LAST ? '0 : cnt_q + CW'(1);
                end
                S_OUT:   st_d = S_DONE;
                default: st_d = S_IDLE;
            endcase
        end
    end

    // state plus Moore outputs decoded from the step being entered; a freeze blanks strobes but keeps wr/addr
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q         <= S_IDLE;
            cnt_q        <= '0;
            clk_en_q     <= 1'b0;
            clr_q        <= 1'b0;
            en_wr_q      <= 1'b0;
            en_rd_q      <= 1'b0;
            wr_q         <= 1'b0;
            en_mac_q     <= 1'b0;
            en_mac_out_q <= 1'b0;
            addr_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            y_valid_q    <= 1'b0;
        end else begin
            st_q         <= st_d;
            cnt_q        <= cnt_d;
            clk_en_q     <= st_d != S_IDLE && !frz;
            clr_q        <= st_d == S_CLR && !frz;
            en_wr_q      <= st_d == S_WRITE && !frz;
            en_rd_q      <= st_d == S_READ && !frz;
            en_mac_q     <= (st_d == S_READ || st_d == S_FLUSH) && !frz;
            en_mac_out_q <= st_d == S_OUT && !frz;
            done_q       <= st_d == S_DONE && !frz;
            busy_q       <= st_d != S_IDLE;
            wr_q         <= frz ? wr_q : st_d == S_WRITE;
            addr_q       <= frz ? addr_q : (st_d == S_WRITE || st_d == S_READ) ? cnt_d[In_Add_W-1:0] : '0;
            y_valid_q    <= st_d == S_DONE ? 1'b1 : (st_q == S_IDLE && start) || (st_q != S_IDLE && abort) ? 1'b0 : y_valid_q;
        end
    end

    assign clk_en     = clk_en_q;
    assign clr        = clr_q;
    assign en_wr      = en_wr_q;
    assign en_rd      = en_rd_q;
    assign wr         = wr_q;
    assign en_MAC     = en_mac_q;
    assign en_MAC_out = en_mac_out_q;
    assign addr       = addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign y_valid    = y_valid_q;
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: two configurations driven in lockstep against a step-index pass model
module tb_conv_seq_ctrl;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, hold = 1'b0, abort = 1'b0;
    logic [1:0] clk_en, clr, en_wr, en_rd, wr, en_mac, en_mac_out, busy, done, y_valid;
    logic [3:0] addr [2];
    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    conv_seq_ctrl #(.R_F(3), .C_F(3), .In_Add_W(4), .MAC_LAT(1)) u0 (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .abort(abort),
        .clk_en(clk_en[0]), .clr(clr[0]), .en_wr(en_wr[0]), .en_rd(en_rd[0]), .wr(wr[0]),
        .en_MAC(en_mac[0]), .en_MAC_out(en_mac_out[0]), .addr(addr[0]),
        .busy(busy[0]), .done(done[0]), .y_valid(y_valid[0]));

    conv_seq_ctrl #(.R_F(2), .C_F(2), .In_Add_W(4), .MAC_LAT(0)) u1 (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .abort(abort),
        .clk_en(clk_en[1]), .clr(clr[1]), .en_wr(en_wr[1]), .en_rd(en_rd[1]), .wr(wr[1]),
        .en_MAC(en_mac[1]), .en_MAC_out(en_mac_out[1]), .addr(addr[1]),
        .busy(busy[1]), .done(done[1]), .y_valid(y_valid[1]));

    // pass model: a pass is a numbered list of steps; p is the step being shown this cycle
    int  mk [2] = '{9, 4};
    int  ml [2] = '{1, 0};
    int  act [2] = '{0, 0};
    int  p [2] = '{0, 0};
    int  eadr [2] = '{0, 0};
    bit  yv [2] = '{0, 0};
    bit  ewr [2] = '{0, 0};
    logic [13:0] expv [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int n, k, l;
            bit fz, ws, rs, fs;
            k  = mk[i];
            l  = ml[i];
            n  = 2 * k + l + 3;
            fz = 1'b0;
            if (rst) begin
                act[i] = 0; p[i] = 0; yv[i] = 1'b0;
            end else if (act[i] == 0) begin
                if (start) begin act[i] = 1; p[i] = 0; yv[i] = 1'b0; end
            end else if (abort) begin
                act[i] = 0; p[i] = 0; yv[i] = 1'b0;
            end else if (hold) begin
                fz = 1'b1;
            end else begin
                p[i]++;
                if (p[i] == n) begin act[i] = 0; p[i] = 0; end
            end
            ws = act[i] != 0 && p[i] >= 1 && p[i] <= k;
            rs = act[i] != 0 && p[i] > k && p[i] <= 2 * k;
            fs = act[i] != 0 && p[i] > 2 * k && p[i] <= 2 * k + l;
            if (act[i] != 0 && p[i] == n - 1) yv[i] = 1'b1;
            if (!fz) begin
                ewr[i]  = ws;
                eadr[i] = ws ? p[i] - 1 : rs ? p[i] - 1 - k : 0;
            end
            expv[i] = {act[i] != 0 && !fz,
                       act[i] != 0 && !fz && p[i] == 0,
                       ws && !fz, rs && !fz, ewr[i], (rs || fs) && !fz,
                       act[i] != 0 && !fz && p[i] == 2 * k + l + 1,
                       act[i] != 0,
                       act[i] != 0 && !fz && p[i] == n - 1,
                       yv[i], 4'(eadr[i])};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [13:0] outs(input int i);
        return {clk_en[i], clr[i], en_wr[i], en_rd[i], wr[i], en_mac[i], en_mac_out[i],
                busy[i], done[i], y_valid[i], addr[i]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check(i == 0 ? "outs0" : "outs1", 32'(outs(i)), 32'(expv[i]));
            check(i == 0 ? "onehot0" : "onehot1",
                  32'($countones({clr[i], en_wr[i], en_rd[i], en_mac_out[i]}) <= 1), 32'd1);
            check(i == 0 ? "addr_max0" : "addr_max1", 32'(int'(addr[i]) <= mk[i] - 1), 32'd1);
        end
    endtask

    task automatic run_sched(input logic [63:0] sm, input logic [63:0] hm, input logic [63:0] am,
                             input logic [63:0] rm, output int l0, output int n0,
                             output int l1, output int n1);
        rst = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0;
        tick();
        rst = 1'b0;
        l0 = -1; n0 = 0; l1 = -1; n1 = 0;
        for (int c = 0; c < 64; c++) begin
            start = sm[c]; hold = hm[c]; abort = am[c]; rst = rm[c];
            tick();
            if (done[0]) begin l0 = c + 1; n0++; end
            if (done[1]) begin l1 = c + 1; n1++; end
        end
        start = 1'b0; hold = 1'b0; abort = 1'b0; rst = 1'b0;
    endtask

    initial begin
        int l0, n0, l1, n1;
        repeat (3) tick();
        check("rst_outs0", 32'(outs(0)), 32'd0);
        check("rst_outs1", 32'(outs(1)), 32'd0);
        rst = 1'b0;
        // plain pass with ignored start pulses while busy
        run_sched(64'h109, 64'h0, 64'h0, 64'h0, l0, n0, l1, n1);
        check("done_cyc0", 32'(l0), 32'd22);
        check("done_cnt0", 32'(n0), 32'd1);
        check("done_cyc1", 32'(l1), 32'd11);
        check("done_cnt1", 32'(n1), 32'd1);
        // three-cycle hold from cycle 5
        run_sched(64'h1, 64'hE0, 64'h0, 64'h0, l0, n0, l1, n1);
        check("hold_done0", 32'(l0), 32'd25);
        check("hold_done1", 32'(l1), 32'd14);
        // abort at 14, restart at 17
        run_sched(64'h20001, 64'h0, 64'h4000, 64'h0, l0, n0, l1, n1);
        check("abort_done0", 32'(l0), 32'd39);
        check("abort_cnt0", 32'(n0), 32'd1);
        check("abort_done1", 32'(l1), 32'd28);
        check("abort_cnt1", 32'(n1), 32'd2);
        // reset mid-READ
        run_sched(64'h1, 64'h0, 64'h0, 64'h1000, l0, n0, l1, n1);
        check("rst_mid_cnt0", 32'(n0), 32'd0);
        check("rst_mid_done1", 32'(l1), 32'd11);
        // back-to-back start at 12
        run_sched(64'h1001, 64'h0, 64'h0, 64'h0, l0, n0, l1, n1);
        check("b2b_done0", 32'(l0), 32'd22);
        check("b2b_done1", 32'(l1), 32'd23);
        check("b2b_cnt1", 32'(n1), 32'd2);
        // random start/hold/abort/rst
        for (int c = 0; c < 3000; c++) begin
            start = $urandom_range(3) == 0;
            hold  = $urandom_range(4) == 0;
            abort = $urandom_range(29) == 0;
            rst   = $urandom_range(199) == 0;
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
